// File: rtl/operand_extender.sv
// Operand extender: widens an instruction operand field (zero/sign/upper modes) behind a
// 2-entry output/skid buffer. Sign mode is built only when OPERAND_EXTENDER_SIGN_EN is defined.
module operand_extender #(
  parameter int IN_OPERAND_LENGTH = 11,
  parameter int EXPECTED_LENGTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_OPERAND_LENGTH-1:0] inOperand,
  input  logic [1:0]                   inMode,
  input  logic                         inValid,
  output logic                         inReady,
  output logic [EXPECTED_LENGTH-1:0]   outOperand,
  output logic                         outValid,
  input  logic                         outReady,
  output logic                         modeError
);

  localparam int PadWidth = EXPECTED_LENGTH - IN_OPERAND_LENGTH;

  generate
    if (EXPECTED_LENGTH <= IN_OPERAND_LENGTH) begin : gIllegalConfig
      $error("operand_extender: EXPECTED_LENGTH must exceed IN_OPERAND_LENGTH");
    end
  endgenerate

  logic [EXPECTED_LENGTH-1:0] extended;
  logic                       badMode;

  always_comb begin
    extended = '0;
    badMode  = 1'b0;
    case (inMode)
      2'b00: extended[IN_OPERAND_LENGTH-1:0] = inOperand;
`ifdef OPERAND_EXTENDER_SIGN_EN
      2'b01: extended = {{PadWidth{inOperand[IN_OPERAND_LENGTH-1]}}, inOperand};
`endif
      2'b10: extended[EXPECTED_LENGTH-1 -: IN_OPERAND_LENGTH] = inOperand;
      default: begin
        // Reserved (and disabled) modes still deliver the zero-extended value.
        extended[IN_OPERAND_LENGTH-1:0] = inOperand;
        badMode = 1'b1;
      end
    endcase
  end

  // Handshake: a word moves on any edge where valid && ready on that side. inReady is a
  // register equal to "skid slot empty", so it never depends on outReady in the same cycle.
  logic                       orValid, srValid, inReadyReg, modeErrorReg;
  logic [EXPECTED_LENGTH-1:0] orData, srData;
  logic                       orValidNext, srValidNext;
  logic [EXPECTED_LENGTH-1:0] orDataNext, srDataNext;
  logic                       accept, consume;

  assign accept  = inValid && inReadyReg;
  assign consume = orValid && outReady;

  always_comb begin
    orValidNext = orValid;
    orDataNext  = orData;
    srValidNext = srValid;
    srDataNext  = srData;
    if (consume) begin
      orValidNext = srValid;
      if (srValid) begin
        orDataNext = srData;
      end
      srValidNext = 1'b0;
    end
    // accept implies the skid slot is empty, so the new word goes to OR if it is free.
    if (accept) begin
      if (!orValidNext) begin
        orValidNext = 1'b1;
        orDataNext  = extended;
      end else begin
        srValidNext = 1'b1;
        srDataNext  = extended;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orValid      <= 1'b0;
      orData       <= '0;
      srValid      <= 1'b0;
      srData       <= '0;
      inReadyReg   <= 1'b0;
      modeErrorReg <= 1'b0;
    end else begin
      orValid      <= orValidNext;
      orData       <= orDataNext;
      srValid      <= srValidNext;
      srData       <= srDataNext;
      inReadyReg   <= !srValidNext;
      modeErrorReg <= modeErrorReg || (accept && badMode);
    end
  end

  assign inReady    = inReadyReg;
  assign outValid   = orValid;
  assign outOperand = orData;
  assign modeError  = modeErrorReg;

endmodule

// File: tb/tb_operand_extender.sv
// Self-checking bench for operand_extender (IN=11, OUT=16): directed vectors, back-pressure,
// random traffic against a 2-deep FIFO reference model, and mid-stream asynchronous reset.
module tb_operand_extender;
  localparam int IW = 11;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] inOperand = '0;
  logic [1:0]    inMode = 2'b00;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [EW-1:0] outOperand;
  logic          outValid;
  logic          outReady = 1'b0;
  logic          modeError;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];
  logic          expReady = 1'b0;
  logic          expErr = 1'b0;

  operand_extender #(.IN_OPERAND_LENGTH(IW), .EXPECTED_LENGTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .inOperand(inOperand), .inMode(inMode), .inValid(inValid),
    .inReady(inReady), .outOperand(outOperand), .outValid(outValid), .outReady(outReady),
    .modeError(modeError)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value from plain arithmetic, MSB of the result flags a bad mode.
  function automatic logic [EW:0] ref_ext(input logic [IW-1:0] op, input logic [1:0] mode);
    longint v;
    logic   bad;
    v   = longint'(op);
    bad = 1'b0;
    case (mode)
      2'd0: v = longint'(op);
      2'd1: begin
`ifdef OPERAND_EXTENDER_SIGN_EN
        if (longint'(op) >= (longint'(1) << (IW - 1)))
          v = longint'(op) + (longint'(1) << EW) - (longint'(1) << IW);
`else
        bad = 1'b1;
`endif
      end
      2'd2: v = longint'(op) * (longint'(1) << (EW - IW));
      default: bad = 1'b1;
    endcase
    return {bad, v[EW-1:0]};
  endfunction

  // Driver: inputs are already set (at a negedge); advance one clock and update the model.
  task automatic cycle();
    bit acc, con;
    logic [EW:0] r;
    acc = rst_n && inValid && expReady;
    con = rst_n && outReady && (exp_q.size() > 0);
    r   = ref_ext(inOperand, inMode);
    @(posedge clk);
    if (rst_n) begin
      if (con) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(r[EW-1:0]);
        if (r[EW]) expErr = 1'b1;
      end
      expReady = (exp_q.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    expReady = 1'b0;
    expErr = 1'b0;
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b0 || modeError !== 1'b0 || outOperand !== '0) begin
      errors++;
      $display("FAIL reset_state: outValid=%b inReady=%b modeError=%b outOperand=%h, want 0 0 0 0000",
               outValid, inReady, modeError, outOperand);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: inReady=%b want 0", inReady);
    end
    @(negedge clk);
    cycle();
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: inReady=%b outValid=%b want 1 0", inReady, outValid);
    end
  endtask

  task automatic test_modes();
    logic [IW-1:0] ops[5];
    logic [1:0]    modes[5];
    logic [EW-1:0] wants[5];
    logic          errs[5];
    ops[0] = 11'h7FF; modes[0] = 2'd0; wants[0] = 16'h07FF; errs[0] = 1'b0;
    ops[1] = 11'h7FF; modes[1] = 2'd2; wants[1] = 16'hFFE0; errs[1] = 1'b0;
`ifdef OPERAND_EXTENDER_SIGN_EN
    ops[2] = 11'h7FF; modes[2] = 2'd1; wants[2] = 16'hFFFF; errs[2] = 1'b0;
    ops[3] = 11'h3FF; modes[3] = 2'd1; wants[3] = 16'h03FF; errs[3] = 1'b0;
`else
    ops[2] = 11'h7FF; modes[2] = 2'd1; wants[2] = 16'h07FF; errs[2] = 1'b1;
    ops[3] = 11'h3FF; modes[3] = 2'd1; wants[3] = 16'h03FF; errs[3] = 1'b1;
`endif
    ops[4] = 11'h001; modes[4] = 2'd3; wants[4] = 16'h0001; errs[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1; inOperand = ops[i]; inMode = modes[i]; outReady = 1'b1;
      cycle();
      checks++;
      if (outValid !== 1'b1 || outOperand !== wants[i] || modeError !== errs[i]) begin
        errors++;
        $display("FAIL mode_vec%0d: outValid=%b outOperand=%h modeError=%b, want 1 %h %b",
                 i, outValid, outOperand, modeError, wants[i], errs[i]);
      end
    end
    inValid = 1'b0;
    repeat (4) cycle();
    checks++;
    if (modeError !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL mode_error_sticky: modeError=%b outValid=%b want 1 0", modeError, outValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] got[$];
    int sent;
    do_reset();
    cycle();
    outReady = 1'b0; inMode = 2'd0; inValid = 1'b1;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      inOperand = IW'(sent + 1);
      if (inValid && expReady) sent++;
      cycle();
    end
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b1 || outOperand !== 16'h0001) begin
      errors++;
      $display("FAIL backpressure_full: inReady=%b outValid=%b outOperand=%h want 0 1 0001",
               inReady, outValid, outOperand);
    end
    outReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (outValid) got.push_back(outOperand);
      if (sent >= 3) inValid = 1'b0;
      inOperand = IW'(sent + 1);
      if (inValid && expReady) sent++;
      cycle();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL drain_count: got %0d results want 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== EW'(i + 1)) begin
        errors++;
        $display("FAIL drain_order%0d: got %h want %h", i, (i < got.size()) ? got[i] : 'x, EW'(i + 1));
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int pass_checks = 0;
    do_reset();
    cycle();
    for (int n = 0; n < 600; n++) begin
      inValid   = ($urandom_range(0, 99) < 70);
      inOperand = IW'($urandom());
      inMode    = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      outReady  = ($urandom_range(0, 99) < ((n / 150) % 2 == 0 ? 80 : 35));
      cycle();
      checks++;
      pass_checks++;
      if (outValid !== (exp_q.size() > 0) || inReady !== expReady || modeError !== expErr ||
          (exp_q.size() > 0 && outOperand !== exp_q[0])) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: outValid=%b inReady=%b modeError=%b outOperand=%h, want %b %b %b %h",
                   n, outValid, inReady, modeError, outOperand, exp_q.size() > 0, expReady, expErr,
                   (exp_q.size() > 0) ? exp_q[0] : outOperand);
      end
    end
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (3) cycle();
    checks++;
    if (outValid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: outValid=%b model_depth=%0d want 0 0", outValid, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cycle();
    outReady = 1'b0; inValid = 1'b1; inMode = 2'd3;
    inOperand = 11'h0AA; cycle();
    inOperand = 11'h0BB; cycle();
    inValid = 1'b0;
    checks++;
    if (inReady !== 1'b0 || outValid !== 1'b1 || modeError !== 1'b1) begin
      errors++;
      $display("FAIL prefill: inReady=%b outValid=%b modeError=%b want 0 1 1", inReady, outValid, modeError);
    end
    #2 rst_n = 1'b0;
    exp_q.delete(); expReady = 1'b0; expErr = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b0 || modeError !== 1'b0 || outOperand !== '0) begin
      errors++;
      $display("FAIL async_reset: outValid=%b inReady=%b modeError=%b outOperand=%h want 0 0 0 0000",
               outValid, inReady, modeError, outOperand);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inValid = 1'b1; inMode = 2'd0; inOperand = 11'h155; outReady = 1'b1;
    cycle();
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_first_edge: outValid=%b inReady=%b want 0 1", outValid, inReady);
    end
    inOperand = 11'h2AA;
    cycle();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outOperand !== 16'h02AA || modeError !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_result: outValid=%b outOperand=%h modeError=%b want 1 02AA 0",
               outValid, outOperand, modeError);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
